// File: rtl/fc_argmax_reader_pkg.sv
// Shared types and sizing for the FC-stage argmax result reader.
package fc_pkg;
  localparam int N_CLASS = 10;
  localparam int DW      = 16;
  localparam int IW      = 4;

  typedef logic signed [DW-1:0] score_t;
  typedef logic [IW-1:0]        idx_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;
endpackage

// File: rtl/fc_argmax_reader_if.sv
// Score capture and result handshake bundle between the FC layer, the reader and the consumer.
interface fc_argmax_if;
  import fc_pkg::*;

  logic                  start;
  logic [N_CLASS*DW-1:0] in_scores;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  idx_t                  class_id;
  score_t                max_score;

  modport slave (
    input  start, in_scores, out_ready,
    output busy, out_valid, class_id, max_score
  );

  modport master (
    output start, in_scores, out_ready,
    input  busy, out_valid, class_id, max_score
  );
endinterface

// File: rtl/fc_argmax_reader_score_cmp.sv
// Signed compare-and-select; the candidate wins only when strictly greater,
// so ties keep the earlier (lower) index.
module fc_score_cmp
  import fc_pkg::*;
(
  input  score_t cand_val,
  input  idx_t   cand_idx,
  input  score_t best_val,
  input  idx_t   best_idx,
  output score_t next_val,
  output idx_t   next_idx
);

  always_comb begin
    next_val = best_val;
    next_idx = best_idx;
    if (cand_val > best_val) begin
      next_val = cand_val;
      next_idx = cand_idx;
    end
  end

endmodule

// File: rtl/fc_argmax_reader.sv
// Snapshots the FC scores on start, scans them one per cycle for the maximum,
// and offers class index and score over a valid/ready handshake.
module fc_argmax_reader
  import fc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  fc_argmax_if.slave  bus
);

  state_t state_q, state_d;
  score_t snap_q [N_CLASS];
  score_t in_unpacked [N_CLASS];
  score_t best_val_q, best_val_d;
  idx_t   best_idx_q, best_idx_d;
  idx_t   idx_q, idx_d;
  idx_t   class_q, class_d;
  score_t max_q, max_d;
  logic   capture;

  score_t cmp_val;
  idx_t   cmp_idx;
  logic   last_idx;

  for (genvar gi = 0; gi < N_CLASS; gi++) begin : g_bank
    assign in_unpacked[gi] = score_t'(bus.in_scores[gi*DW +: DW]);

    always_ff @(posedge clk) begin
      if (rst) begin
        snap_q[gi] <= '0;
      end else if (capture) begin
        snap_q[gi] <= in_unpacked[gi];
      end
    end
  end

  fc_score_cmp u_cmp (
    .cand_val (snap_q[idx_q]),
    .cand_idx (idx_q),
    .best_val (best_val_q),
    .best_idx (best_idx_q),
    .next_val (cmp_val),
    .next_idx (cmp_idx)
  );

  assign last_idx = (idx_q == IW'(N_CLASS - 1));

  always_comb begin
    state_d    = state_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    idx_d      = idx_q;
    class_d    = class_q;
    max_d      = max_q;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          capture    = 1'b1;
          best_val_d = in_unpacked[0];
          best_idx_d = '0;
          idx_d      = IW'(1);
          state_d    = SCAN;
        end
      end
      SCAN: begin
        best_val_d = cmp_val;
        best_idx_d = cmp_idx;
        idx_d      = idx_q + IW'(1);
        if (last_idx) begin
          // Result registers only update here so they hold across later captures.
          class_d = cmp_idx;
          max_d   = cmp_val;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      best_val_q <= '0;
      best_idx_q <= '0;
      idx_q      <= '0;
      class_q    <= '0;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      idx_q      <= idx_d;
      class_q    <= class_d;
      max_q      <= max_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.class_id  = class_q;
  assign bus.max_score = max_q;

endmodule

// File: tb/tb_fc_argmax_reader.sv
// Directed bench for fc_argmax_reader: latency, tie-break, signed order, stall, abort, back-to-back.
module tb_fc_argmax_reader;
  import fc_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  score_t sc [N_CLASS];

  fc_argmax_if bus ();

  fc_argmax_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_scores();
    for (int k = 0; k < N_CLASS; k++) begin
      bus.in_scores[k*DW +: DW] = sc[k];
    end
  endtask

  // Pulses start for one edge, then counts edges until out_valid (bounded).
  task automatic do_start(output int lat);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_scores = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b valid=%b required 0 0", bus.busy, bus.out_valid);
    end
    n_checks++;
    if (bus.class_id !== 4'd0 || bus.max_score !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset_outs: class=%0d max=%0d required 0 0", bus.class_id, bus.max_score);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: busy=%b valid=%b class=%0d max=%0d", bus.busy, bus.out_valid, bus.class_id, bus.max_score);
  endtask

  task automatic test_tie();
    int lat;
    sc = '{16'sd0, 16'sd5, 16'sd3, 16'sd120, 16'sd7, 16'sd0, 16'sd9, 16'sd120, 16'sd1, 16'sd2};
    load_scores();
    bus.out_ready = 1'b1;
    do_start(lat);
    n_checks++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL tie_latency: got %0d required 9", lat);
    end
    n_checks++;
    if (bus.class_id !== 4'd3 || bus.max_score !== 16'sd120) begin
      n_fail++;
      $display("FAIL tie_result: class=%0d max=%0d required 3 120", bus.class_id, bus.max_score);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.class_id !== 4'd3) begin
      n_fail++;
      $display("FAIL tie_after_hs: valid=%b busy=%b class=%0d required 0 0 3", bus.out_valid, bus.busy, bus.class_id);
    end
    $display("tie: lat=%0d class=%0d max=%0d", lat, bus.class_id, bus.max_score);
  endtask

  task automatic test_all_zero();
    int lat;
    for (int k = 0; k < N_CLASS; k++) sc[k] = 16'sd0;
    load_scores();
    do_start(lat);
    n_checks++;
    if (lat !== 9 || bus.class_id !== 4'd0 || bus.max_score !== 16'sd0) begin
      n_fail++;
      $display("FAIL all_zero: lat=%0d class=%0d max=%0d required 9 0 0", lat, bus.class_id, bus.max_score);
    end
    @(posedge clk); #1;
    $display("all_zero: lat=%0d class=%0d max=%0d", lat, bus.class_id, bus.max_score);
  endtask

  task automatic test_signed();
    int lat;
    sc = '{-16'sd5, -16'sd1, -16'sd32768, -16'sd2, -16'sd3, -16'sd3, -16'sd3, -16'sd3, -16'sd3, -16'sd3};
    load_scores();
    do_start(lat);
    n_checks++;
    if (lat !== 9 || bus.class_id !== 4'd1 || bus.max_score !== -16'sd1) begin
      n_fail++;
      $display("FAIL signed: lat=%0d class=%0d max=%0d required 9 1 -1", lat, bus.class_id, bus.max_score);
    end
    @(posedge clk); #1;
    $display("signed: lat=%0d class=%0d max=%0d", lat, bus.class_id, bus.max_score);
  endtask

  task automatic test_stall();
    int lat;
    sc = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd50, 16'sd6, 16'sd7, 16'sd8, 16'sd9, 16'sd10};
    load_scores();
    bus.out_ready = 1'b0;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < N_CLASS; k++) sc[k] = 16'sd0;
    sc[7] = 16'sd200;
    load_scores();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 3;
    while (!bus.out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL stall_latency: got %0d required 9", lat);
    end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.class_id !== 4'd4 || bus.max_score !== 16'sd50) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid=%b busy=%b class=%0d max=%0d required 1 1 4 50",
                 c, bus.out_valid, bus.busy, bus.class_id, bus.max_score);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hs: valid=%b busy=%b required 0 0", bus.out_valid, bus.busy);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_no_queue%0d: valid=%b busy=%b required 0 0", c, bus.out_valid, bus.busy);
      end
    end
    $display("stall: lat=%0d class=%0d max=%0d", lat, bus.class_id, bus.max_score);
  endtask

  task automatic test_rst_mid_scan();
    int lat;
    for (int k = 0; k < N_CLASS; k++) sc[k] = score_t'(k);
    load_scores();
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.class_id !== 4'd0 || bus.max_score !== 16'sd0) begin
      n_fail++;
      $display("FAIL rst_abort: busy=%b valid=%b class=%0d max=%0d required 0 0 0 0",
               bus.busy, bus.out_valid, bus.class_id, bus.max_score);
    end
    repeat (10) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_no_result: valid=%b required 0", bus.out_valid);
      end
    end
    for (int k = 0; k < N_CLASS; k++) sc[k] = 16'sd0;
    sc[9] = 16'sd1000;
    load_scores();
    do_start(lat);
    n_checks++;
    if (lat !== 9 || bus.class_id !== 4'd9 || bus.max_score !== 16'sd1000) begin
      n_fail++;
      $display("FAIL rst_fresh: lat=%0d class=%0d max=%0d required 9 9 1000", lat, bus.class_id, bus.max_score);
    end
    @(posedge clk); #1;
    $display("rst_mid_scan: lat=%0d class=%0d max=%0d", lat, bus.class_id, bus.max_score);
  endtask

  task automatic test_back_to_back();
    int lat;
    sc = '{16'sd10, 16'sd20, 16'sd30, 16'sd40, 16'sd45, 16'sd44, 16'sd43, 16'sd42, 16'sd41, 16'sd40};
    load_scores();
    bus.out_ready = 1'b1;
    do_start(lat);
    n_checks++;
    if (lat !== 9 || bus.class_id !== 4'd4 || bus.max_score !== 16'sd45) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d class=%0d max=%0d required 9 4 45", lat, bus.class_id, bus.max_score);
    end
    sc = '{16'sd7, 16'sd6, 16'sd5, 16'sd4, 16'sd3, 16'sd2, 16'sd1, 16'sd0, 16'sd6, 16'sd7};
    load_scores();
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: valid=%b busy=%b required 0 0", bus.out_valid, bus.busy);
    end
    do_start(lat);
    n_checks++;
    if (lat !== 9 || bus.class_id !== 4'd0 || bus.max_score !== 16'sd7) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d class=%0d max=%0d required 9 0 7", lat, bus.class_id, bus.max_score);
    end
    @(posedge clk); #1;
    $display("back_to_back: lat=%0d class=%0d max=%0d", lat, bus.class_id, bus.max_score);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_tie();
    test_all_zero();
    test_signed();
    test_stall();
    test_rst_mid_scan();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
